// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS frequency-sweep controller.
//   sweep_state_t : sweep FSM state encoding
//   FW_W_DEF      : default frequency-word width (must match the DDS core)
//   DWELL_MIN     : smallest effective dwell, in clkout0 cycles
package dds_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DWELL,
      STEP,
      DONE
   } sweep_state_t;

   localparam int FW_W_DEF  = 30;
   localparam int DWELL_MIN = 1;

endpackage

// File: rtl/dds_next_fw.sv
// Next-point calculator for the sweep staircase (purely combinational).
//   cur  : frequency word currently driven to the DDS
//   stop : final frequency word of the pass
//   step : unsigned step magnitude
//   dir  : 1 = sweep up, 0 = sweep down
//   next : cur +/- step, clamped to stop on overshoot, overflow or underflow
//   last : current point ends the pass (cur == stop, or step == 0)
module dds_next_fw
   import dds_ctrl_pkg::*;
#(
   parameter int FW_W = FW_W_DEF
) (
   input  logic [FW_W-1:0] cur,
   input  logic [FW_W-1:0] stop,
   input  logic [FW_W-1:0] step,
   input  logic            dir,
   output logic [FW_W-1:0] next,
   output logic            last
);

   // One extra bit catches carry-out above 2^FW_W-1 and borrow below 0.
   logic [FW_W:0] sum;
   logic [FW_W:0] diff;

   always_comb begin
      sum  = {1'b0, cur} + {1'b0, step};
      diff = {1'b0, cur} - {1'b0, step};
      if (dir) begin
         next = (sum[FW_W] || (sum[FW_W-1:0] > stop)) ? stop : sum[FW_W-1:0];
      end else begin
         next = (diff[FW_W] || (diff[FW_W-1:0] < stop)) ? stop : diff[FW_W-1:0];
      end
      last = (cur == stop) || (step == '0);
   end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS tone generators (clkout0 domain).
// Holds a shadow sweep configuration and walks freq_word through a timed
// staircase from start to stop, pulsing fw_update at every new point.
//   clkout0, rst_n      : DDS clock, asynchronous active-low reset
//   cfg_valid/cfg_ready : config write handshake (ready only when idle)
//   cfg_start_fw/stop_fw/step_fw/dwell/cont : sweep configuration
//   start, abort        : one-cycle sweep start / stop requests
//   freq_word, fw_update: DDS frequency word and its one-cycle update strobe
//   busy, done          : sweep in progress / single-sweep completion pulse
//   sweep_cnt           : completed passes, wrapping
module dds_sweep_ctrl
   import dds_ctrl_pkg::*;
#(
   parameter int FW_W    = FW_W_DEF,
   parameter int DWELL_W = 24,
   parameter int CNT_W   = 16
) (
   input  logic               clkout0,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [FW_W-1:0]    cfg_start_fw,
   input  logic [FW_W-1:0]    cfg_stop_fw,
   input  logic [FW_W-1:0]    cfg_step_fw,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_cont,
   input  logic               start,
   input  logic               abort,
   output logic [FW_W-1:0]    freq_word,
   output logic               fw_update,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sweep_cnt
);

   sweep_state_t state, state_nxt;

   logic [FW_W-1:0]    start_sh, stop_sh, step_sh;
   logic [DWELL_W-1:0] dwell_sh;
   logic               cont_sh;
   logic               dir_up;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DWELL_W-1:0] dwell_eff;
   logic               dwell_end;
   logic [FW_W-1:0]    next_fw;
   logic               last_pt;
   logic               do_cfg, do_load, do_step, cnt_inc;

   dds_next_fw #(.FW_W(FW_W)) u_next_fw (
      .cur  (freq_word),
      .stop (stop_sh),
      .step (step_sh),
      .dir  (dir_up),
      .next (next_fw),
      .last (last_pt)
   );

   // dwell_cnt is 1 in the cycle a point first appears, so a point is held
   // for exactly dwell_eff cycles and the step lands on the final count.
   assign dwell_eff = (dwell_sh < DWELL_W'(DWELL_MIN)) ? DWELL_W'(DWELL_MIN) : dwell_sh;
   assign dwell_end = (dwell_cnt == dwell_eff);

   assign cfg_ready = (state == IDLE);
   assign busy      = (state == LOAD) || (state == DWELL) || (state == STEP);
   assign done      = (state == DONE);

   always_ff @(posedge clkout0 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // STEP never occupies a cycle: the step decision is taken on the final
   // dwell count, so the LOAD of the next point happens on the same edge.
   always_comb begin
      state_nxt = state;
      do_cfg    = 1'b0;
      do_load   = 1'b0;
      do_step   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_valid) begin
               do_cfg = 1'b1;            // config beats a simultaneous start
            end else if (start) begin
               state_nxt = LOAD;
               do_load   = 1'b1;
            end
         end
         LOAD, DWELL, STEP: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (dwell_end) begin
               if (last_pt) begin
                  cnt_inc = 1'b1;
                  if (cont_sh) begin
                     state_nxt = LOAD;
                     do_load   = 1'b1;
                  end else begin
                     state_nxt = DONE;
                  end
               end else begin
                  state_nxt = DWELL;
                  do_step   = 1'b1;
               end
            end else begin
               state_nxt = DWELL;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clkout0 or negedge rst_n) begin
      if (!rst_n) begin
         start_sh <= '0;
         stop_sh  <= '0;
         step_sh  <= '0;
         dwell_sh <= '0;
         cont_sh  <= 1'b0;
      end else if (do_cfg) begin
         start_sh <= cfg_start_fw;
         stop_sh  <= cfg_stop_fw;
         step_sh  <= cfg_step_fw;
         dwell_sh <= cfg_dwell;
         cont_sh  <= cfg_cont;
      end
   end

   always_ff @(posedge clkout0 or negedge rst_n) begin
      if (!rst_n) begin
         freq_word <= '0;
         fw_update <= 1'b0;
         dir_up    <= 1'b1;
         dwell_cnt <= '0;
         sweep_cnt <= '0;
      end else begin
         fw_update <= do_load | do_step;
         if (do_load) begin
            freq_word <= start_sh;
            dir_up    <= (stop_sh >= start_sh);
            dwell_cnt <= DWELL_W'(1);
         end else if (do_step) begin
            freq_word <= next_fw;
            dwell_cnt <= DWELL_W'(1);
         end else if (busy) begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
         end
         if (cnt_inc) sweep_cnt <= sweep_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus pushes the expected
// update/done events (value and spacing in cycles); a negedge monitor pops
// and compares whenever fw_update or done is presented.
module tb_dds_sweep_ctrl;

   localparam int FW_W    = 30;
   localparam int DWELL_W = 24;
   localparam int CNT_W   = 16;
   localparam logic [FW_W-1:0] TOP_M5 = 30'h3FFF_FFFB;
   localparam logic [FW_W-1:0] TOP_M1 = 30'h3FFF_FFFF;

   logic               clkout0 = 1'b0;
   logic               rst_n   = 1'b0;
   logic               cfg_valid = 1'b0;
   logic               cfg_ready;
   logic [FW_W-1:0]    cfg_start_fw = '0;
   logic [FW_W-1:0]    cfg_stop_fw  = '0;
   logic [FW_W-1:0]    cfg_step_fw  = '0;
   logic [DWELL_W-1:0] cfg_dwell    = '0;
   logic               cfg_cont     = 1'b0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [FW_W-1:0]    freq_word;
   logic               fw_update;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   sweep_cnt;

   dds_sweep_ctrl #(.FW_W(FW_W), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
      .clkout0      (clkout0),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_start_fw (cfg_start_fw),
      .cfg_stop_fw  (cfg_stop_fw),
      .cfg_step_fw  (cfg_step_fw),
      .cfg_dwell    (cfg_dwell),
      .cfg_cont     (cfg_cont),
      .start        (start),
      .abort        (abort),
      .freq_word    (freq_word),
      .fw_update    (fw_update),
      .busy         (busy),
      .done         (done),
      .sweep_cnt    (sweep_cnt)
   );

   always #5 clkout0 = ~clkout0;

   typedef struct {
      bit               is_done;
      logic [FW_W-1:0]  fw;
      logic [CNT_W-1:0] cnt;
      int               gap;      // cycles since previous event, -1 = unchecked
   } ev_t;

   ev_t q[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic void push_upd(input logic [FW_W-1:0] fw, input int gap);
      ev_t e;
      e.is_done = 1'b0; e.fw = fw; e.cnt = '0; e.gap = gap;
      q.push_back(e);
   endfunction

   function automatic void push_done(input logic [CNT_W-1:0] cnt, input int gap);
      ev_t e;
      e.is_done = 1'b1; e.fw = '0; e.cnt = cnt; e.gap = gap;
      q.push_back(e);
   endfunction

   // Monitor
   initial begin : monitor
      int  cyc;
      int  last_cyc;
      ev_t e;
      cyc = 0;
      last_cyc = 0;
      forever begin
         @(negedge clkout0);
         cyc++;
         if (rst_n && (fw_update || done)) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_event: got fw_update=%0d done=%0d freq_word=%0d expected no event at %0t",
                        fw_update, done, freq_word, $time);
            end else begin
               e = q.pop_front();
               if (e.is_done) begin
                  check("done_evt", {62'd0, done, fw_update}, 64'd2);
                  check("done_cnt", 64'(sweep_cnt), 64'(e.cnt));
               end else begin
                  check("upd_evt", {62'd0, done, fw_update}, 64'd1);
                  check("upd_fw", 64'(freq_word), 64'(e.fw));
               end
               if (e.gap >= 0) check("event_gap", 64'(cyc - last_cyc), 64'(e.gap));
            end
            last_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clkout0);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic cfg(input logic [FW_W-1:0] s, input logic [FW_W-1:0] p,
                      input logic [FW_W-1:0] st, input logic [DWELL_W-1:0] d,
                      input logic c);
      cfg_valid = 1'b1;
      cfg_start_fw = s; cfg_stop_fw = p; cfg_step_fw = st;
      cfg_dwell = d; cfg_cont = c;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (!cfg_ready && k < 300) begin
         tick();
         k++;
      end
      if (!cfg_ready) begin
         n_chk++;
         $display("FAIL wait_idle: got cfg_ready=0 expected 1 within 300 cycles");
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      // Reset state
      #3;
      check("rst_freq_word", 64'(freq_word), 64'd0);
      check("rst_fw_update", 64'(fw_update), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sweep_cnt", 64'(sweep_cnt), 64'd0);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      ticks(2);
      rst_n = 1'b1;
      tick();

      // 1: basic up sweep, dwell 4
      cfg(100, 130, 10, 4, 1'b0);
      push_upd(100, -1); push_upd(110, 4); push_upd(120, 4); push_upd(130, 4);
      push_done(1, 4);
      go();
      check("t1_latency_upd", 64'(fw_update), 64'd1);
      check("t1_latency_fw", 64'(freq_word), 64'd100);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_cfg_ready", 64'(cfg_ready), 64'd0);
      wait_idle();
      check("t1_sweep_cnt", 64'(sweep_cnt), 64'd1);
      check("t1_hold_stop", 64'(freq_word), 64'd130);

      // 2: overshoot clamp, then down sweep
      cfg(0, 25, 10, 3, 1'b0);
      push_upd(0, -1); push_upd(10, 3); push_upd(20, 3); push_upd(25, 3);
      push_done(2, 3);
      go(); wait_idle();
      cfg(50, 20, 15, 3, 1'b0);
      push_upd(50, -1); push_upd(35, 3); push_upd(20, 3);
      push_done(3, 3);
      go(); wait_idle();

      // 3: top-end overflow clamps to stop
      cfg(TOP_M5, TOP_M1, 10, 2, 1'b0);
      push_upd(TOP_M5, -1); push_upd(TOP_M1, 2);
      push_done(4, 2);
      go(); wait_idle();
      check("t3_hold_top", 64'(freq_word), 64'(TOP_M1));

      // 4: continuous, then abort on a completing dwell
      cfg(0, 20, 10, 2, 1'b1);
      push_upd(0, -1); push_upd(10, 2); push_upd(20, 2); push_upd(0, 2);
      push_upd(10, 2); push_upd(20, 2); push_upd(0, 2); push_upd(10, 2);
      go();                  // cycle t
      ticks(7);              // cycle t+7
      check("t4_cnt_wrap1", 64'(sweep_cnt), 64'd5);
      ticks(8);              // cycle t+15: last dwell cycle of 10
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_abort_busy", 64'(busy), 64'd0);
      check("t4_abort_fw", 64'(freq_word), 64'd10);
      check("t4_abort_ready", 64'(cfg_ready), 64'd1);
      check("t4_abort_cnt", 64'(sweep_cnt), 64'd6);
      ticks(4);

      // 5a: dwell 0 acts as 1
      cfg(5, 8, 1, 0, 1'b0);
      push_upd(5, -1); push_upd(6, 1); push_upd(7, 1); push_upd(8, 1);
      push_done(7, 1);
      go(); wait_idle();

      // 5b: step 0 gives a single point
      cfg(40, 90, 0, 3, 1'b0);
      push_upd(40, -1);
      push_done(8, 3);
      go(); wait_idle();

      // 5c: cfg writes while busy are ignored
      cfg(1000, 1030, 10, 2, 1'b0);
      push_upd(1000, -1); push_upd(1010, 2); push_upd(1020, 2); push_upd(1030, 2);
      push_done(9, 2);
      go();
      cfg_valid = 1'b1;
      cfg_start_fw = 0; cfg_stop_fw = 5; cfg_step_fw = 1; cfg_dwell = 1; cfg_cont = 1'b1;
      tick();
      check("t5c_ready_busy", 64'(cfg_ready), 64'd0);
      tick();
      cfg_valid = 1'b0;
      wait_idle();
      push_upd(1000, -1); push_upd(1010, 2); push_upd(1020, 2); push_upd(1030, 2);
      push_done(10, 2);
      go(); wait_idle();

      // 5d: start together with cfg_valid stores config only
      cfg_start_fw = 7; cfg_stop_fw = 7; cfg_step_fw = 0; cfg_dwell = 1; cfg_cont = 1'b0;
      cfg_valid = 1'b1;
      start = 1'b1;
      tick();
      cfg_valid = 1'b0;
      start = 1'b0;
      check("t5d_no_busy", 64'(busy), 64'd0);
      check("t5d_ready", 64'(cfg_ready), 64'd1);
      ticks(3);
      push_upd(7, -1);
      push_done(11, 1);
      go(); wait_idle();

      // 6: asynchronous reset mid-dwell
      cfg(200, 300, 10, 5, 1'b0);
      push_upd(200, -1);
      go();
      ticks(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_fw", 64'(freq_word), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_cnt", 64'(sweep_cnt), 64'd0);
      check("t6_rst_ready", 64'(cfg_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_ready_after", 64'(cfg_ready), 64'd1);
      push_upd(0, -1);
      push_done(1, 1);
      go(); wait_idle();
      check("t6_hold_zero", 64'(freq_word), 64'd0);

      ticks(3);
      check("queue_empty", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
